fizzbuzz_checker: RTL and testbench

//  Receive end of the fizz/buzz/fizzbuzz stream produced by the FizzBuzz model.

---
 rtl/fizzbuzz_pkg.sv | 27 ++
 rtl/fizzbuzz_checker_mod_counter.sv | 36 +++
 rtl/fizzbuzz_checker.sv | 125 ++++++++++++
 tb/tb_fizzbuzz_checker.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared types for the FizzBuzz stream checker:
// FSM states, the received/expected code bundle and the code generator.
package fizzbuzz_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic fizz;
      logic buzz;
      logic fizzbuzz;
   } fb_code_t;

   // Exclusive encoding: at most one flag is ever expected high.
   function automatic fb_code_t expected_code(input logic m3_zero,
                                              input logic m5_zero);
      fb_code_t c;
      c.fizzbuzz = m3_zero & m5_zero;
      c.fizz     = m3_zero & ~m5_zero;
      c.buzz     = ~m3_zero & m5_zero;
      return c;
   endfunction

endpackage

// File: rtl/fizzbuzz_checker_mod_counter.sv
// Modulo-DIV phase counter; stands in for a divider when tracking
// whether the current sequence index is a multiple of DIV.
module mod_counter #(
   parameter int DIV  = 3,
   parameter int INIT = 0,
   localparam int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         is_zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = (cnt_q == W'(DIV - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= W'(INIT);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count   = cnt_q;
   assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/fizzbuzz_checker.sv
// Receive-side checker for a fizz/buzz/fizzbuzz stream: compares each
// valid beat with the expected code and reports errors and completion.
module fizzbuzz_checker
   import fizzbuzz_pkg::*;
#(
   parameter int MAX_CYCLES = 30,
   parameter int FIZZ_DIV   = 3,
   parameter int BUZZ_DIV   = 5,
   parameter int START_IDX  = 1,
   parameter int ERR_W      = 8,
   localparam int IDX_W     = $clog2(MAX_CYCLES + START_IDX) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic             fizz,
   input  logic             buzz,
   input  logic             fizzbuzz,
   output logic [IDX_W-1:0] idx,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_count,
   output logic             overrun,
   output logic             done,
   output logic             pass
);

   localparam int M3_W = (FIZZ_DIV > 1) ? $clog2(FIZZ_DIV) : 1;
   localparam int M5_W = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] beat_q, beat_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             mis_q, mis_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             ovr_q, ovr_d;

   logic             accept;
   logic             m3_zero, m5_zero;
   logic [M3_W-1:0]  m3_cnt;
   logic [M5_W-1:0]  m5_cnt;
   fb_code_t         rx_code, exp_code;
   logic             beat_bad;

   wire unused_cnt = ^{m3_cnt, m5_cnt};

   assign accept = valid && (state_q != DONE);

   mod_counter #(
      .DIV  (FIZZ_DIV),
      .INIT (START_IDX % FIZZ_DIV)
   ) u_m3 (
      .clk     (clk),
      .reset   (reset),
      .en      (accept),
      .count   (m3_cnt),
      .is_zero (m3_zero)
   );

   mod_counter #(
      .DIV  (BUZZ_DIV),
      .INIT (START_IDX % BUZZ_DIV)
   ) u_m5 (
      .clk     (clk),
      .reset   (reset),
      .en      (accept),
      .count   (m5_cnt),
      .is_zero (m5_zero)
   );

   // Illegal multi-flag combos never equal the one-hot-or-zero expectation.
   always_comb begin
      rx_code.fizz     = fizz;
      rx_code.buzz     = buzz;
      rx_code.fizzbuzz = fizzbuzz;
      exp_code         = expected_code(m3_zero, m5_zero);
      beat_bad         = (rx_code != exp_code);
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      idx_d   = idx_q;
      mis_d   = 1'b0;
      err_d   = err_q;
      ovr_d   = ovr_q;
      if (accept) begin
         beat_d = beat_q + 1'b1;
         idx_d  = IDX_W'(START_IDX) + beat_q;
         mis_d  = beat_bad;
         if (beat_bad && (err_q != '1)) begin
            err_d = err_q + 1'b1;
         end
         state_d = (beat_d == IDX_W'(MAX_CYCLES)) ? DONE : RUN;
      end
      if (valid && (state_q == DONE)) begin
         ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         idx_q   <= '0;
         mis_q   <= 1'b0;
         err_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         idx_q   <= idx_d;
         mis_q   <= mis_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

   assign idx       = idx_q;
   assign mismatch  = mis_q;
   assign err_count = err_q;
   assign overrun   = ovr_q;
   assign done      = (state_q == DONE);
   assign pass      = done && (err_q == '0);

endmodule

// File: tb/tb_fizzbuzz_checker.sv
// Directed and randomized stimulus for fizzbuzz_checker, checked against
// an arithmetic model of the FizzBuzz sequence.
module tb_fizzbuzz_checker;

   localparam int MAXC = 30;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       valid = 1'b0;
   logic       fizz = 1'b0;
   logic       buzz = 1'b0;
   logic       fizzbuzz = 1'b0;
   logic [5:0] idx, idx2;
   logic       mismatch, mismatch2;
   logic [7:0] err_count;
   logic [1:0] err_count2;
   logic       overrun, overrun2;
   logic       done, done2;
   logic       pass, pass2;

   int vectors = 0;
   int miscompares = 0;

   int m_n = 0;
   int m_err = 0;
   logic m_mis = 1'b0;
   logic m_ovr = 1'b0;

   always #5 clk = ~clk;

   fizzbuzz_checker dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .fizz      (fizz),
      .buzz      (buzz),
      .fizzbuzz  (fizzbuzz),
      .idx       (idx),
      .mismatch  (mismatch),
      .err_count (err_count),
      .overrun   (overrun),
      .done      (done),
      .pass      (pass)
   );

   fizzbuzz_checker #(.ERR_W(2)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .fizz      (fizz),
      .buzz      (buzz),
      .fizzbuzz  (fizzbuzz),
      .idx       (idx2),
      .mismatch  (mismatch2),
      .err_count (err_count2),
      .overrun   (overrun2),
      .done      (done2),
      .pass      (pass2)
   );

   // {fizz,buzz,fizzbuzz} for sequence index n
   function automatic logic [2:0] fb_exp(input int n);
      if (n % 15 == 0) return 3'b001;
      if (n % 3 == 0)  return 3'b100;
      if (n % 5 == 0)  return 3'b010;
      return 3'b000;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [2:0] code);
      logic dn;
      @(negedge clk);
      reset = r;
      valid = v;
      {fizz, buzz, fizzbuzz} = code;
      @(posedge clk);
      if (r) begin
         m_n = 0; m_err = 0; m_mis = 1'b0; m_ovr = 1'b0;
      end else if (v && m_n == MAXC) begin
         m_ovr = 1'b1; m_mis = 1'b0;
      end else if (v) begin
         m_n++;
         m_mis = (code != fb_exp(m_n));
         if (m_mis) m_err++;
      end else begin
         m_mis = 1'b0;
      end
      #1;
      dn = (m_n == MAXC);
      chk("idx", int'(idx), m_n);
      chk("mismatch", int'(mismatch), int'(m_mis));
      chk("err_count", int'(err_count), (m_err > 255) ? 255 : m_err);
      chk("err_count_w2", int'(err_count2), (m_err > 3) ? 3 : m_err);
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("done", int'(done), int'(dn));
      chk("pass", int'(pass), int'(dn && m_err == 0));
      chk("pass_w2", int'(pass2), int'(dn && m_err == 0));
   endtask

   task automatic do_reset();
      step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
   endtask

   initial begin
      // golden stream
      do_reset();
      for (int n = 1; n <= MAXC; n++) step(1'b0, 1'b1, fb_exp(n));
      chk("t1_idx_end", int'(idx), 30);
      chk("t1_pass_end", int'(pass), 1);

      // n=9 carries buzz instead of fizz
      do_reset();
      for (int n = 1; n <= MAXC; n++)
         step(1'b0, 1'b1, (n == 9) ? 3'b010 : fb_exp(n));
      chk("t2_err_end", int'(err_count), 1);
      chk("t2_pass_end", int'(pass), 0);

      // half-rate valid with garbage on stall cycles
      do_reset();
      for (int n = 1; n <= MAXC; n++) begin
         step(1'b0, 1'b0, 3'($urandom_range(0, 7)));
         step(1'b0, 1'b1, fb_exp(n));
      end
      chk("t3_pass_end", int'(pass), 1);

      // illegal fizz+buzz combo at n=15
      do_reset();
      for (int n = 1; n <= MAXC; n++)
         step(1'b0, 1'b1, (n == 15) ? 3'b110 : fb_exp(n));
      chk("t4_err_end", int'(err_count), 1);

      // reset mid-run, then fresh stream
      do_reset();
      for (int n = 1; n <= 12; n++) step(1'b0, 1'b1, (n == 4) ? 3'b111 : fb_exp(n));
      do_reset();
      for (int n = 1; n <= MAXC; n++) step(1'b0, 1'b1, fb_exp(n));
      chk("t5_pass_end", int'(pass), 1);

      // every beat corrupted, then overrun
      do_reset();
      for (int n = 1; n <= MAXC; n++)
         step(1'b0, 1'b1, fb_exp(n) ^ 3'($urandom_range(1, 7)));
      chk("t6_sat_w2", int'(err_count2), 3);
      step(1'b0, 1'b1, 3'b000);
      step(1'b0, 1'b0, 3'b000);
      chk("t6_overrun_w2", int'(overrun2), 1);
      chk("t6_sat_hold_w2", int'(err_count2), 3);

      // random traffic with occasional corruption and resets
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic [2:0] c;
         c = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : fb_exp(m_n + 1);
         step(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
